// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Start/busy/done handshake; bcd only updates on the completing edge.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  operand_reg, operand_next;
    logic [BW-1:0]     scratch_reg, scratch_next;
    logic [BW-1:0]     bcd_reg, bcd_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              done_reg, done_next;
    logic [BW-1:0]     adjusted;
    logic [BW-1:0]     shifted;

    // Add-3 correction on every digit in parallel, ahead of the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
            assign adjusted[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                       ? scratch_reg[gi*4 +: 4] + 4'd3
                                       : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adjusted[BW-2:0], operand_reg[WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            operand_reg <= '0;
            scratch_reg <= '0;
            bcd_reg     <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            operand_reg <= operand_next;
            scratch_reg <= scratch_next;
            bcd_reg     <= bcd_next;
            count_reg   <= count_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        operand_next = operand_reg;
        scratch_next = scratch_reg;
        bcd_next     = bcd_reg;
        count_next   = count_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    operand_next = bin;
                    scratch_next = '0;
                    count_next   = CW'(WIDTH);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_next = shifted;
                operand_next = {operand_reg[WIDTH-2:0], 1'b0};
                count_next   = count_reg - CW'(1);
                // Last bit shifted in: publish the finished value only now.
                if (count_reg == CW'(1)) begin
                    bcd_next   = shifted;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected BCD pushed on acceptance,
// popped and compared whenever the DUT pulses done.
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [BW-1:0]    bcd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] exp_q[$];
    int            m_rem  = 0;
    logic          m_done = 1'b0;
    logic [BW-1:0] m_bcd  = '0;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on each edge from the sampled inputs, then outputs are checked.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_bcd  = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    exp_q.push_back(to_bcd(int'(bin)));
                    m_rem = WIDTH;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(m_rem != 0));
        chk("done", 32'(done), 32'(m_done));
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("done_without_request", 32'(done), 32'(0));
            end else begin
                m_bcd = exp_q.pop_front();
                $display("result bcd=%03h expected=%03h", bcd, m_bcd);
                chk("bcd_result", 32'(bcd), 32'(m_bcd));
            end
        end else begin
            chk("bcd_hold", 32'(bcd), 32'(m_bcd));
        end
    end

    task automatic convert(input int v);
        @(negedge clk);
        start = 1'b1;
        bin   = WIDTH'(v);
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        convert(0);
        convert(15);
        chk("downstream_low_byte", 32'(bcd[7:0]), 32'h15);
        convert(255);
        convert(99);
        convert(100);

        // Start while busy must be ignored; bin changes while busy have no effect.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd42;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'd77;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);

        // Reset mid-conversion aborts with no done.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd9;
        @(negedge clk);
        bin   = 8'd10;
        repeat (WIDTH + 1) @(negedge clk);
        bin   = 8'd11;
        repeat (WIDTH + 1) @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            bin   = WIDTH'($urandom);
        end
        start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
